// File: rtl/fp_pkg.sv
// Shared types and defaults for the floating-point adder arbiter.
//  FP_W    : default operand width (sign + exponent + mantissa)
//  state_e : arbiter FSM states
package fp_pkg;

  localparam int unsigned FP_EXP_LEN      = 8;
  localparam int unsigned FP_MANTISSA_LEN = 23;
  localparam int unsigned FP_W            = FP_EXP_LEN + FP_MANTISSA_LEN + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of i_pending at or after i_ptr, wrapping
// from N-1 back to 0.
//  i_pending : request vector
//  i_ptr     : search start index
//  o_grant   : selected index (0 when nothing is pending)
//  o_any     : at least one bit of i_pending is set
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  i_pending,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_grant,
  output logic          o_any
);

  int w_idx;

  // Scan from the farthest offset down so the nearest pending index wins.
  always_comb begin
    o_grant = '0;
    o_any   = |i_pending;
    w_idx   = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      w_idx = int'(i_ptr) + k;
      if (w_idx >= int'(N)) w_idx = w_idx - int'(N);
      if (i_pending[w_idx]) o_grant = IW'(w_idx);
    end
  end

endmodule

// File: rtl/fp_add_arbiter.sv
// Shares one floating-point adder among NUM_REQ requesters, granting it
// round-robin and routing each sum back with a one-cycle ready pulse.
//  clock, reset_n      : rising-edge clock, asynchronous active-low reset
//  req_start/a/b       : per-requester start pulse and operands (slice i*W +: W)
//  req_sum/ready/busy  : routed result, one-hot result pulse, pending flags
//  add_a/b/start       : adder operands and start pulse
//  add_sum/ready       : adder result and its valid pulse
//  err_overrun/timeout : sticky error flags, cleared only by reset
module fp_add_arbiter
  import fp_pkg::*;
#(
  parameter  int unsigned EXP_LEN      = FP_EXP_LEN,
  parameter  int unsigned MANTISSA_LEN = FP_MANTISSA_LEN,
  parameter  int unsigned NUM_REQ      = 4,
  parameter  int unsigned TIMEOUT_CYC  = 64,
  localparam int unsigned W            = EXP_LEN + MANTISSA_LEN + 1
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_start,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  output logic [W-1:0]         req_sum,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   req_busy,
  output logic [W-1:0]         add_a,
  output logic [W-1:0]         add_b,
  output logic                 add_start,
  input  logic [W-1:0]         add_sum,
  input  logic                 add_ready,
  output logic [NUM_REQ-1:0]   err_overrun,
  output logic                 err_timeout
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  state_e             r_state;
  logic [NUM_REQ-1:0] r_pending;
  logic [W-1:0]       r_op_a [NUM_REQ];
  logic [W-1:0]       r_op_b [NUM_REQ];
  logic [IW-1:0]      r_ptr;
  logic [IW-1:0]      r_grant;
  logic [CW-1:0]      r_cnt;

  logic [IW-1:0]      w_pick;
  logic               w_any;
  logic               w_done;
  logic [NUM_REQ-1:0] w_clear;
  logic [NUM_REQ-1:0] w_accept;
  logic [NUM_REQ-1:0] w_overrun;
  logic [IW-1:0]      w_ptr_next;

  assign req_busy = r_pending;

  rr_pick #(.N(NUM_REQ), .IW(IW)) u_rr_pick (
    .i_pending (r_pending),
    .i_ptr     (r_ptr),
    .o_grant   (w_pick),
    .o_any     (w_any)
  );

  // Completion (result or timeout) frees the granted slot this cycle, so a
  // start arriving on that same slot is accepted rather than flagged.
  always_comb begin
    w_done  = 1'b0;
    w_clear = '0;
    if (r_state == WAIT && (add_ready || r_cnt == CW'(TIMEOUT_CYC - 1))) begin
      w_done           = 1'b1;
      w_clear[r_grant] = 1'b1;
    end
    w_accept   = req_start & (~r_pending | w_clear);
    w_overrun  = req_start & r_pending & ~w_clear;
    w_ptr_next = (r_grant == IW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
  end

  // Operand latches, pending flags and the IDLE -> ISSUE -> WAIT sequencer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_ptr       <= '0;
      r_grant     <= '0;
      r_cnt       <= '0;
      req_sum     <= '0;
      req_ready   <= '0;
      add_a       <= '0;
      add_b       <= '0;
      add_start   <= 1'b0;
      err_overrun <= '0;
      err_timeout <= 1'b0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        r_op_a[i] <= '0;
        r_op_b[i] <= '0;
      end
    end else begin
      req_ready   <= '0;
      err_overrun <= err_overrun | w_overrun;
      r_pending   <= (r_pending & ~w_clear) | w_accept;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
        if (w_accept[i]) begin
          r_op_a[i] <= req_a[i*W +: W];
          r_op_b[i] <= req_b[i*W +: W];
        end
      end

      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant   <= w_pick;
            add_a     <= r_op_a[w_pick];
            add_b     <= r_op_b[w_pick];
            add_start <= 1'b1;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          add_start <= 1'b0;
          r_cnt     <= '0;
          r_state   <= WAIT;
        end
        WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (add_ready) begin
            req_sum            <= add_sum;
            req_ready[r_grant] <= 1'b1;
            r_ptr              <= w_ptr_next;
            r_state            <= IDLE;
          end else if (w_done) begin
            // Abandon the request; any late result lands in IDLE and is dropped.
            err_timeout <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_add_arbiter.sv
module tb_fp_add_arbiter;

  localparam int W = 32;
  localparam int N = 4;

  localparam logic [31:0] ZERO   = 32'h0000_0000;
  localparam logic [31:0] ONE    = 32'h3F80_0000;
  localparam logic [31:0] TWO    = 32'h4000_0000;
  localparam logic [31:0] THREE  = 32'h4040_0000;
  localparam logic [31:0] PI     = 32'h4049_0FDB;
  localparam logic [31:0] TWO_PI = 32'h40C9_0FDB;

  logic           clock = 1'b0;
  logic           reset_n = 1'b0;
  logic [N-1:0]   req_start = '0;
  logic [N*W-1:0] req_a = '0;
  logic [N*W-1:0] req_b = '0;
  logic [W-1:0]   req_sum;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_busy;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic           add_start;
  logic [W-1:0]   add_sum = '0;
  logic           add_ready = 1'b0;
  logic [N-1:0]   err_overrun;
  logic           err_timeout;

  fp_add_arbiter dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_start   (req_start),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_sum     (req_sum),
    .req_ready   (req_ready),
    .req_busy    (req_busy),
    .add_a       (add_a),
    .add_b       (add_b),
    .add_start   (add_start),
    .add_sum     (add_sum),
    .add_ready   (add_ready),
    .err_overrun (err_overrun),
    .err_timeout (err_timeout)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Known sums for the operand pairs used here.
  function automatic logic [31:0] fp_sum(input logic [31:0] a, input logic [31:0] b);
    if (a == ZERO) return b;
    if (b == ZERO) return a;
    if ((a == ONE && b == TWO) || (a == TWO && b == ONE)) return THREE;
    if (a == ONE && b == ONE) return TWO;
    if (a == PI && b == PI) return TWO_PI;
    return 32'hDEAD_BEEF;
  endfunction

  // Adder model: answers lat cycles after seeing add_start, unless muted.
  bit          mute = 1'b0;
  int          lat = 3;
  int          inj_cnt = 0;
  int          inj_seen = 0;
  int          m_cnt = 0;
  bit          m_pend = 1'b0;
  logic [31:0] m_res = '0;

  always @(negedge clock) begin
    add_ready = 1'b0;
    if (m_pend) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        add_ready = 1'b1;
        add_sum   = m_res;
        m_pend    = 1'b0;
      end
    end
    if (inj_cnt != inj_seen) begin
      inj_seen  = inj_cnt;
      add_ready = 1'b1;
      add_sum   = 32'h1234_5678;
    end
    if (add_start && !mute) begin
      m_pend = 1'b1;
      m_cnt  = lat;
      m_res  = fp_sum(add_a, add_b);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b);
    req_start[idx]     = 1'b1;
    req_a[idx*W +: W]  = a;
    req_b[idx*W +: W]  = b;
  endtask

  task automatic wait_ready(input string name, input logic [N-1:0] exp_mask,
                            input logic [31:0] exp_sum);
    bit got;
    got = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (req_ready != '0) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: no req_ready within 200 cycles, expected mask %b", name, exp_mask);
    end else begin
      chk({name, "_mask"}, 64'(req_ready), 64'(exp_mask));
      chk({name, "_sum"}, 64'(req_sum), 64'(exp_sum));
      chk({name, "_busy_clr"}, 64'(req_busy & exp_mask), 64'd0);
    end
  endtask

  // Single request on an idle arbiter, with exact add_start latency.
  task automatic run_one(input string name, input int idx, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_sum);
    tick();
    set_req(idx, a, b);
    tick();
    req_start = '0;
    chk({name, "_busy"}, 64'(req_busy), 64'(N'(1) << idx));
    chk({name, "_start_early"}, 64'(add_start), 64'd0);
    tick();
    chk({name, "_start"}, 64'(add_start), 64'd1);
    chk({name, "_add_ops"}, {add_a, add_b}, {a, b});
    wait_ready(name, N'(1) << idx, exp_sum);
    tick();
    chk({name, "_pulse_len"}, 64'(req_ready), 64'd0);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
  } vec_t;

  vec_t vecs[4];

  initial begin
    bit seen;
    int cyc;

    vecs[0] = '{idx: 0, a: ONE,  b: TWO, sum: THREE};
    vecs[1] = '{idx: 1, a: ONE,  b: ONE, sum: TWO};
    vecs[2] = '{idx: 2, a: PI,   b: PI,  sum: TWO_PI};
    vecs[3] = '{idx: 3, a: ZERO, b: PI,  sum: PI};

    repeat (3) tick();
    chk("reset_outs", 64'({req_ready, req_busy, add_start, err_overrun, err_timeout}), 64'd0);
    chk("reset_sum", 64'(req_sum), 64'd0);
    reset_n = 1'b1;

    // Single requests, one per requester.
    foreach (vecs[v]) run_one($sformatf("single%0d", v), vecs[v].idx, vecs[v].a, vecs[v].b, vecs[v].sum);

    // All four at once from rr_ptr = 0.
    tick();
    for (int i = 0; i < N; i++) set_req(i, vecs[i].a, vecs[i].b);
    tick();
    req_start = '0;
    chk("all4_busy", 64'(req_busy), 64'hF);
    for (int j = 0; j < N; j++) wait_ready($sformatf("all4_g%0d", j), N'(1) << j, vecs[j].sum);
    chk("all4_no_overrun", 64'(err_overrun), 64'd0);

    // Wrap: last grant 2, then 1 and 3 pending -> 3 first.
    run_one("wrap_pre", 2, PI, PI, TWO_PI);
    tick();
    set_req(1, ONE, ONE);
    set_req(3, ONE, TWO);
    tick();
    req_start = '0;
    wait_ready("wrap_first", 4'b1000, THREE);
    wait_ready("wrap_second", 4'b0010, TWO);

    // Overrun: second start on busy requester 2 is dropped.
    tick();
    set_req(2, PI, PI);
    tick();
    set_req(2, ONE, TWO);
    tick();
    req_start = '0;
    chk("overrun_flag", 64'(err_overrun), 64'b0100);
    wait_ready("overrun_orig", 4'b0100, TWO_PI);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (add_start || req_busy != '0 || req_ready != '0) seen = 1'b1;
    end
    chk("overrun_not_executed", 64'(seen), 64'd0);

    // Timeout: adder silent, flag after 64 WAIT cycles.
    mute = 1'b1;
    tick();
    set_req(0, ONE, TWO);
    cyc  = 0;
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      req_start = '0;
      cyc++;
      if (req_ready != '0) seen = 1'b1;
      if (err_timeout) break;
    end
    chk("timeout_cycle", 64'(cyc), 64'd67);
    chk("timeout_flag", 64'(err_timeout), 64'd1);
    chk("timeout_busy_clr", 64'(req_busy), 64'd0);
    chk("timeout_no_ready", 64'(seen), 64'd0);
    inj_cnt++;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (req_ready != '0) seen = 1'b1;
    end
    chk("late_ready_ignored", 64'(seen), 64'd0);
    mute = 1'b0;
    run_one("after_timeout", 0, ONE, ONE, TWO);

    // Reset in the middle of WAIT.
    lat = 10;
    tick();
    set_req(1, ONE, ONE);
    tick();
    req_start = '0;
    repeat (3) tick();
    chk("pre_reset_ops", 64'(add_a), 64'(ONE));
    reset_n = 1'b0;
    #1;
    chk("mid_reset_outs", 64'({req_ready, req_busy, add_start, err_overrun, err_timeout}), 64'd0);
    chk("mid_reset_data", {add_a, req_sum}, 64'd0);
    repeat (2) tick();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (req_ready != '0 || req_busy != '0 || add_start) seen = 1'b1;
    end
    chk("stale_after_reset", 64'(seen), 64'd0);
    lat = 3;
    run_one("after_reset", 3, PI, PI, TWO_PI);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
